// File: rtl/demux4_dispatch_pkg.sv
// ============================================================================
// Module   : demux_pkg
// Purpose  : Shared types and destination codes for the 1-to-4 result dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package demux_pkg;

  localparam int NUM_OUT = 4;

  typedef logic [1:0] dest_sel_t;

  localparam dest_sel_t DEST_ALU = 2'd0;
  localparam dest_sel_t DEST_LSU = 2'd1;
  localparam dest_sel_t DEST_CSR = 2'd2;
  localparam dest_sel_t DEST_BR  = 2'd3;

  function automatic logic [NUM_OUT-1:0] dest_onehot(input dest_sel_t sel);
    logic [NUM_OUT-1:0] w_oh;
    w_oh = '0;
    w_oh[sel] = 1'b1;
    return w_oh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux4_dispatch_slot.sv
// ============================================================================
// Module   : demux_slot
// Purpose  : One-entry holding buffer with valid/ready drain and pipeline flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             can_accept
);

  logic             occ_q;
  logic             occ_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Priority: flush beats a fill, a fill beats a drain (drain+fill keeps valid).
  always_comb begin
    occ_d = occ_q;
    if (valid && ready) begin
      occ_d = 1'b0;
    end
    if (wr_en) begin
      occ_d = 1'b1;
    end
    if (flush) begin
      occ_d = 1'b0;
    end
  end

  // Data is only ever overwritten by a new word; an emptied slot keeps its last value.
  always_comb begin
    data_d = data_q;
    if (wr_en) begin
      data_d = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= 1'b0;
      data_q <= '0;
    end else begin
      occ_q  <= occ_d;
      data_q <= data_d;
    end
  end

  assign valid      = occ_q;
  assign data       = data_q;
  assign can_accept = ~occ_q | ready;

endmodule

`default_nettype wire

// File: rtl/demux4_dispatch.sv
// ============================================================================
// Module   : demux4_dispatch
// Purpose  : Registered 1-to-4 valid/ready demultiplexer with per-channel slots.
//            Optional per-channel handshake counters: DEMUX4_DISPATCH_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux4_dispatch
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  dest_sel_t          in_sel,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [WIDTH-1:0]   out_data0,
  output logic [WIDTH-1:0]   out_data1,
  output logic [WIDTH-1:0]   out_data2,
  output logic [WIDTH-1:0]   out_data3
`ifdef DEMUX4_DISPATCH_PERF_CNT_EN
  ,
  output logic [16*NUM_OUT-1:0] perf_cnt
`endif
);

  logic [NUM_OUT-1:0] w_can_accept;
  logic [NUM_OUT-1:0] w_wr_en;
  logic [WIDTH-1:0]   w_slot_data [NUM_OUT];

  // Only the targeted slot gates acceptance; in_valid never feeds in_ready.
  assign in_ready = ~flush & w_can_accept[in_sel];
  assign w_wr_en  = (in_valid && in_ready) ? dest_onehot(in_sel) : '0;

  generate
    for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
      demux_slot #(
        .WIDTH (WIDTH)
      ) u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .wr_en      (w_wr_en[i]),
        .wr_data    (in_data),
        .valid      (out_valid[i]),
        .ready      (out_ready[i]),
        .data       (w_slot_data[i]),
        .can_accept (w_can_accept[i])
      );
    end
  endgenerate

  assign out_data0 = w_slot_data[DEST_ALU];
  assign out_data1 = w_slot_data[DEST_LSU];
  assign out_data2 = w_slot_data[DEST_CSR];
  assign out_data3 = w_slot_data[DEST_BR];

`ifdef DEMUX4_DISPATCH_PERF_CNT_EN
  // Counters see every handshake, including one coincident with a flush.
  generate
    for (genvar i = 0; i < NUM_OUT; i++) begin : g_perf
      logic [15:0] cnt_q;
      logic [15:0] cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (out_valid[i] && out_ready[i]) begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign perf_cnt[16*i +: 16] = cnt_q;
    end
  endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux4_dispatch.sv
// ============================================================================
// Module   : tb_demux4_dispatch
// Purpose  : Scoreboard bench for demux4_dispatch with a queue-based channel model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux4_dispatch;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
`ifdef DEMUX4_DISPATCH_PERF_CNT_EN
  logic [63:0]      perf_cnt;
`endif

  demux4_dispatch #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3)
`ifdef DEMUX4_DISPATCH_PERF_CNT_EN
    ,
    .perf_cnt  (perf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each channel is a FIFO of words owed to its consumer.
  logic [WIDTH-1:0] exp_q [4][$];
  logic [WIDTH-1:0] last_d [4];
  int unsigned      hs_cnt [4];
  int               total = 0;
  int               bad   = 0;
  int               accepts = 0;

  logic [WIDTH-1:0] od [4];
  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      exp_q[i].delete();
      last_d[i] = '0;
      hs_cnt[i] = 0;
    end
  endtask

  // Monitor: compares DUT outputs with the model and retires completed handshakes.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", {63'd0, in_ready},
          {63'd0, (!flush && (exp_q[in_sel].size() == 0 || out_ready[in_sel]))});
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("out_valid[%0d]", i), {63'd0, out_valid[i]},
            {63'd0, (exp_q[i].size() != 0)});
        if (exp_q[i].size() != 0) begin
          chk($sformatf("out_data%0d", i), {32'd0, od[i]}, {32'd0, exp_q[i][0]});
          if (out_ready[i]) begin
            void'(exp_q[i].pop_front());
            hs_cnt[i]++;
          end
        end else begin
          chk($sformatf("out_data%0d_idle", i), {32'd0, od[i]}, {32'd0, last_d[i]});
        end
      end
    end
  end

  // Drive one cycle of stimulus, then record what the model says the DUT accepts.
  task automatic step(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                      input logic [3:0] ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #6;
    if (rst_n) begin
      if (fl) begin
        for (int i = 0; i < 4; i++) exp_q[i].delete();
      end else if (v && (exp_q[s].size() == 0 || ordy[s])) begin
        exp_q[s].push_back(d);
        last_d[s] = d;
        accepts++;
      end
    end
  endtask

  task automatic chk_perf();
`ifdef DEMUX4_DISPATCH_PERF_CNT_EN
    for (int i = 0; i < 4; i++)
      chk($sformatf("perf_cnt[%0d]", i), {48'd0, perf_cnt[16*i +: 16]},
          {48'd0, hs_cnt[i][15:0]});
`endif
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sel = 2'd0;
    in_data = '0; out_ready = 4'b0000;
    model_reset();
    #12;
    chk("reset out_valid", {60'd0, out_valid}, 64'd0);
    chk("reset out_data2", {32'd0, out_data2}, 64'd0);
    #4 rst_n = 1'b1;

    // Single word to CSR channel, then a blocked second word and a bypass to LSU.
    step(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000, 1'b0);
    step(1'b1, 2'd2, 32'h12345678, 4'b0000, 1'b0);
    step(1'b1, 2'd1, 32'hCAFEF00D, 4'b0000, 1'b0);
    step(1'b0, 2'd0, 32'h0,        4'b1111, 1'b0);
    step(1'b0, 2'd0, 32'h0,        4'b0000, 1'b0);

    // Back-to-back stream into channel 0.
    accepts = 0;
    for (int k = 1; k <= 8; k++) step(1'b1, 2'd0, k, 4'b0001, 1'b0);
    step(1'b0, 2'd0, 32'h0, 4'b0001, 1'b0);
    chk("stream accepts", accepts, 64'd8);

    // Fill all four slots, probe every select, then open channel 3 only.
    for (int k = 0; k < 4; k++) step(1'b1, k[1:0], 32'hA000 + k, 4'b0000, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, k[1:0], 32'h0, 4'b0000, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, k[1:0], 32'h0, 4'b1000, 1'b0);

    // Flush with three occupied slots and a word offered the same cycle.
    step(1'b1, 2'd0, 32'hB0, 4'b0000, 1'b0);
    step(1'b1, 2'd3, 32'hF1F1, 4'b0000, 1'b1);
    step(1'b0, 2'd0, 32'h0, 4'b0000, 1'b0);
    chk("post-flush out_valid", {60'd0, out_valid}, 64'd0);
    chk_perf();

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom,
           4'($urandom), 1'($urandom_range(0, 15) == 0));
    end
    chk_perf();

    // Async reset in the middle of traffic.
    step(1'b1, 2'd1, 32'h55, 4'b0000, 1'b0);
    step(1'b1, 2'd2, 32'h66, 4'b0000, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("async reset out_valid", {60'd0, out_valid}, 64'd0);
    model_reset();
    chk_perf();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
           4'($urandom), 1'b0);
    end
    step(1'b0, 2'd0, 32'h0, 4'b1111, 1'b0);
    chk_perf();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/demux4_dispatch.md
Name: demux4_dispatch

Overview:
- Registered 1-to-4 demultiplexer with valid/ready handshakes. It is the dispatch-side counterpart of the 4:1 select muxes in the RISC-V datapath.
- Routes one WIDTH-bit result word to one of four consumers (e.g. ALU writeback, LSU, CSR, branch unit) selected by a 2-bit code.
- Each output has a one-entry holding slot, so a stalled consumer backpressures only traffic aimed at it.

Parameters:
- WIDTH, 32, data word width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all holding slots (pipeline flush).
- in_valid  input  1  input word present.
- in_ready  output  1  input word will be accepted this cycle.
- in_data  input  WIDTH  word to dispatch.
- in_sel  input  2  destination: 0..3 selects out0..out3.
- out_valid  output  4  per-destination slot occupied; bit i belongs to channel i.
- out_ready  input  4  per-destination consumer accepts.
- out_data0..out_data3  output  WIDTH each  per-destination slot data.

Behaviour:
- Reset (rst_n low, async): all slot-occupied flags 0, so out_valid=4'b0000; out_data0..3=0; in_ready follows its combinational equation.
- Input handshake: a word transfers on a rising edge where in_valid & in_ready.
- in_ready = ~flush & (~occ[in_sel] | out_ready[in_sel]). This is combinational and depends only on the targeted slot.
- Latency: a word accepted at edge N appears on out_valid[sel]/out_data<sel> after edge N, i.e. 1 cycle.
- Output handshake: channel i drains on an edge where out_valid[i] & out_ready[i].
  - While out_valid[i]=1 and out_ready[i]=0, out_data<i> is held stable.
  - A slot never drops valid without a handshake or a flush.
- Simultaneous drain + fill of the same slot: the new word replaces the old one and out_valid stays 1. This gives full throughput, one word per cycle per channel.
- Drain of channel i and fill of channel j≠i in the same cycle are independent.
- Only the selected slot's data register is written. Non-selected slots keep their data.
- When a slot empties, its data register keeps the last value (not zeroed).
- flush=1 at an edge:
  - all occ cleared, so out_valid=0 the next cycle;
  - in_ready=0, so no word is accepted that cycle;
  - data registers unchanged.
- flush takes priority over a simultaneous output handshake; the consumer still sees that handshake as a completed transfer.
- Full condition: all four slots occupied and no out_ready asserted, so in_ready=0 for every in_sel value.
- in_sel and in_data are don't-care when in_valid=0. in_ready may still toggle with in_sel.
- Reset asserted mid-transfer: all slots are cleared immediately and in-flight words are lost.
- No combinational path from in_valid to in_ready.

Optional Feature:
- Macro: DEMUX4_DISPATCH_PERF_CNT_EN.
- When defined:
  - Adds output perf_cnt, 4x16 bits packed ({ch3,ch2,ch1,ch0}).
  - Counter i increments by 1 on every completed output handshake of channel i.
  - Counters wrap 16'hFFFF→0, reset to 0 on rst_n, and are not affected by flush.
- When undefined: port and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package demux_pkg holds:
  - localparam NUM_OUT=4;
  - typedef logic [1:0] dest_sel_t;
  - named constants DEST_ALU=0, DEST_LSU=1, DEST_CSR=2, DEST_BR=3.
- Natural sub-module: demux_slot, a one-entry buffer with WIDTH parameter.
  - Ports: clk, rst_n, flush, wr_en, wr_data, valid, ready, data, can_accept.
  - Instantiated 4 times.
- The top level holds only select decode, in_ready muxing and the optional counters.

Test Plan:
- Reset, then in_valid=1, in_sel=2, in_data=32'hDEADBEEF, out_ready=4'b0000 → in_ready=1; next cycle out_valid=4'b0100 and out_data2=32'hDEADBEEF; other channels stay 0.
- Slot 2 full with out_ready[2]=0, then send in_sel=2 → in_ready=0 and out_data2 holds DEADBEEF. With in_sel=1 in the same state → in_ready=1 and the word lands in slot 1.
- Back-to-back stream to channel 0 of 8 words 1..8 with out_ready[0]=1 → one word per cycle and in_ready constantly 1; channel 0 sees 1..8 in order with no gaps.
- All four slots filled with out_ready=0 → in_ready=0 for in_sel=0..3. Then pulse out_ready[3] for one cycle → in_ready=1 only for in_sel=3.
- flush=1 with 3 slots occupied and in_valid=1 → in_ready=0 that cycle; next cycle out_valid=0000, and the word is not captured.
- DEMUX4_DISPATCH_PERF_CNT_EN defined: 5 handshakes on ch1 and 2 on ch3 → perf_cnt ch1=5, ch3=2, others 0. Preload ch0 near 16'hFFFF and drive 2 more ch0 handshakes → ch0 wraps to 0 then 1. Assert rst_n low mid-stream → all counters 0 and out_valid=0 immediately (async).
